// File: rtl/prt_dptx_sdp_serializer.sv
`default_nettype none
// ============================================================================
// Module   : prt_dptx_sdp_serializer
// Purpose  : Buffers 320-bit AE_SDP payloads in a small FIFO and streams each
//            one as ten 32-bit words (word 0 first) on a valid/ready link.
//            A packet starts only while the blanking window is open.
//            Reports sticky overflow and a count of completed packets.
// Revision : 1.0 - initial release
// ============================================================================
module prt_dptx_sdp_serializer #(
  parameter int P_DEPTH    = 2,
  parameter int P_IDLE_GAP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cke,
  input  logic         sdp_valid,
  input  logic [319:0] sdp_payload,
  input  logic         blank,
  input  logic         tx_ready,
  output logic         tx_valid,
  output logic [31:0]  tx_data,
  output logic         tx_sop,
  output logic         tx_eop,
  output logic         busy,
  output logic         ovf,
  input  logic         ovf_clr,
  output logic [15:0]  pkt_cnt
);

  localparam int c_AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int c_GW = $clog2(P_IDLE_GAP + 1) + 1;
  localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(P_DEPTH);
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((P_IDLE_GAP > 0) ? (P_IDLE_GAP - 1) : 0);
  localparam logic [3:0]      c_LAST_K   = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  logic [319:0]    r_mem [P_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            r_head_settled;
  state_t          r_state;
  logic [3:0]      r_k;
  logic [c_GW-1:0] r_gap;
  logic            r_tx_valid;
  logic [31:0]     r_tx_data;
  logic            r_tx_sop;
  logic            r_tx_eop;
  logic            r_ovf;
  logic [15:0]     r_pkt_cnt;

  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic [319:0]    w_head;
  logic [3:0]      w_next_k;
  logic [31:0]     w_next_word;

  // A slot freed by the eop transfer can take a write on the same edge.
  assign w_full      = (r_count == c_FULL);
  assign w_pop       = cke && (r_state == S_SEND) && tx_ready && (r_k == c_LAST_K);
  assign w_push      = sdp_valid && (!w_full || w_pop);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_next_k    = r_k + 4'd1;
  assign w_next_word = w_head[{w_next_k, 5'd0} +: 32];

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign tx_sop   = r_tx_sop;
  assign tx_eop   = r_tx_eop;
  assign ovf      = r_ovf;
  assign pkt_cnt  = r_pkt_cnt;
  assign busy     = (r_state != S_IDLE) || (r_count != '0);

  // Payload storage; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= sdp_payload;
  end

  // FIFO pointers, occupancy and a one-cycle settle flag for a fresh head entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_head_settled <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (c_AW + 1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (c_AW + 1)'(1);
      r_head_settled <= (r_count != '0);
    end
  end

  // Sticky overflow: a dropped write wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (sdp_valid && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Transmit FSM with registered stream outputs; everything frozen while cke=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_k        <= 4'd0;
      r_gap      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 32'd0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_pkt_cnt  <= 16'd0;
    end else if (cke) begin
      case (r_state)
        S_IDLE: begin
          if ((r_count != '0) && r_head_settled && blank) begin
            r_state    <= S_SEND;
            r_k        <= 4'd0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_head[31:0];
            r_tx_sop   <= 1'b1;
            r_tx_eop   <= 1'b0;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (r_k == c_LAST_K) begin
              r_k        <= 4'd0;
              r_gap      <= '0;
              r_tx_valid <= 1'b0;
              r_tx_data  <= 32'd0;
              r_tx_sop   <= 1'b0;
              r_tx_eop   <= 1'b0;
              r_pkt_cnt  <= r_pkt_cnt + 16'd1;
              r_state    <= (P_IDLE_GAP == 0) ? S_IDLE : S_GAP;
            end else begin
              r_k        <= w_next_k;
              r_tx_data  <= w_next_word;
              r_tx_sop   <= 1'b0;
              r_tx_eop   <= (w_next_k == c_LAST_K);
            end
          end
        end
        S_GAP: begin
          if (r_gap == c_GAP_LAST) r_state <= S_IDLE;
          else                     r_gap   <= r_gap + c_GW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prt_dptx_sdp_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_prt_dptx_sdp_serializer
// Purpose  : Self-checking bench: table-driven single packet, directed corner
//            sequences, then randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prt_dptx_sdp_serializer;

  localparam int P_DEPTH    = 2;
  localparam int P_IDLE_GAP = 2;

  logic         clk = 1'b0;
  logic         rst, cke, sdp_valid, blank, tx_ready, ovf_clr;
  logic [319:0] sdp_payload;
  logic         tx_valid, tx_sop, tx_eop, busy, ovf;
  logic [31:0]  tx_data;
  logic [15:0]  pkt_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  prt_dptx_sdp_serializer #(.P_DEPTH(P_DEPTH), .P_IDLE_GAP(P_IDLE_GAP)) dut (
    .clk(clk), .rst(rst), .cke(cke), .sdp_valid(sdp_valid), .sdp_payload(sdp_payload),
    .blank(blank), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        ready;
    logic        blank;
    logic        v;
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic        busy;
  } vec_t;

  vec_t tbl[18];

  // Queue model state for the random phase
  logic [319:0] m_q[$];
  int           m_k   = 0;
  int           m_pkt = 0;
  logic         m_ovf = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [319:0] mk_payload(input logic [31:0] base);
    logic [319:0] p;
    for (int j = 0; j < 10; j++) p[j*32 +: 32] = base + 32'(j);
    return p;
  endfunction

  // Receive one packet word by word; idle counts the cycles spent before word 0.
  task automatic recv(input string name, input logic [319:0] exp_p, input bit inject,
                      input logic [319:0] inj_p, output int idle);
    int waited;
    idle = 0;
    for (int k = 0; k < 10; k++) begin
      waited = 0;
      while (!(tx_valid && tx_ready && cke) && waited < 200) begin
        if (k == 0) idle++;
        tick();
        waited++;
      end
      if (waited >= 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_timeout: word %0d never transferred", name, k);
        return;
      end
      chk($sformatf("%s_w%0d", name, k), {32'd0, tx_data}, {32'd0, exp_p[k*32 +: 32]});
      chk($sformatf("%s_sop%0d", name, k), {63'd0, tx_sop}, {63'd0, (k == 0)});
      chk($sformatf("%s_eop%0d", name, k), {63'd0, tx_eop}, {63'd0, (k == 9)});
      if (inject && k == 9) begin
        sdp_valid   = 1'b1;
        sdp_payload = inj_p;
      end
      tick();
      sdp_valid = 1'b0;
    end
  endtask

  // One cycle of random (or draining) traffic checked against the queue model.
  task automatic rand_step(input bit drain);
    logic [319:0] p, h;
    bit xfer, pop, do_push;
    if (drain) begin
      cke = 1'b1; tx_ready = 1'b1; blank = 1'b1; sdp_valid = 1'b0; ovf_clr = 1'b0;
    end else begin
      cke      = ($urandom_range(3) != 0);
      tx_ready = ($urandom_range(3) != 0);
      if ($urandom_range(29) == 0) blank = ~blank;
      sdp_valid = ($urandom_range(9) == 0);
      ovf_clr   = ($urandom_range(24) == 0);
      for (int j = 0; j < 10; j++) p[j*32 +: 32] = $urandom();
      sdp_payload = p;
    end
    xfer = tx_valid && tx_ready && cke;
    if (tx_valid) begin
      if (m_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rnd_spurious: tx_valid=1 with no packet queued");
      end else begin
        h = m_q[0];
        chk("rnd_data", {32'd0, tx_data}, {32'd0, h[m_k*32 +: 32]});
        chk("rnd_sop", {63'd0, tx_sop}, {63'd0, (m_k == 0)});
        chk("rnd_eop", {63'd0, tx_eop}, {63'd0, (m_k == 9)});
      end
    end
    pop     = xfer && (m_k == 9);
    do_push = sdp_valid && ((m_q.size() < P_DEPTH) || pop);
    if (sdp_valid && !do_push) m_ovf = 1'b1;
    else if (ovf_clr)          m_ovf = 1'b0;
    if (xfer) m_k = (m_k == 9) ? 0 : m_k + 1;
    if (pop) begin
      void'(m_q.pop_front());
      m_pkt++;
    end
    if (do_push) m_q.push_back(sdp_payload);
    tick();
    chk("rnd_ovf", {63'd0, ovf}, {63'd0, m_ovf});
    chk("rnd_pkt", {48'd0, pkt_cnt}, {48'd0, 16'(m_pkt)});
    if (m_q.size() != 0) chk("rnd_busy", {63'd0, busy}, 64'd1);
  endtask

  initial begin
    int idle, words, waited;
    logic pv, ps, pe;
    logic [31:0] pd;
    logic [319:0] qa, q1, q2, q3, q4, q5, q6;

    //             ready blank v  data  sop eop busy
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'd4, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'd6, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 32'd8, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'd9, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; cke = 1'b1; sdp_valid = 1'b0; sdp_payload = '0;
    blank = 1'b1; tx_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_data", {32'd0, tx_data}, 64'd0);
    chk("rst_sop", {63'd0, tx_sop}, 64'd0);
    chk("rst_eop", {63'd0, tx_eop}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_pkt", {48'd0, pkt_cnt}, 64'd0);

    // Single packet with backpressure and blank falling mid-packet
    sdp_valid = 1'b1; sdp_payload = mk_payload(32'd0);
    tick();
    sdp_valid = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tx_ready = tbl[i].ready;
      blank    = tbl[i].blank;
      chk($sformatf("tbl%0d_valid", i), {63'd0, tx_valid}, {63'd0, tbl[i].v});
      chk($sformatf("tbl%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].busy});
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_data", i), {32'd0, tx_data}, {32'd0, tbl[i].d});
        chk($sformatf("tbl%0d_sop", i), {63'd0, tx_sop}, {63'd0, tbl[i].sop});
        chk($sformatf("tbl%0d_eop", i), {63'd0, tx_eop}, {63'd0, tbl[i].eop});
      end
      tick();
    end
    chk("single_pkt", {48'd0, pkt_cnt}, 64'd1);

    // Blank gating: packet waits while blank=0
    tx_ready = 1'b1; blank = 1'b0;
    qa = mk_payload(32'h100);
    sdp_valid = 1'b1; sdp_payload = qa;
    tick();
    sdp_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("gate_valid", {63'd0, tx_valid}, 64'd0);
      chk("gate_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    blank = 1'b1;
    recv("gate", qa, 1'b0, '0, idle);
    chk("gate_pkt", {48'd0, pkt_cnt}, 64'd2);
    repeat (5) tick();

    // Overflow: third strobe dropped, clear, then clear coincident with overflow
    blank = 1'b0;
    q1 = mk_payload(32'h1000); q2 = mk_payload(32'h2000);
    q3 = mk_payload(32'h3000); q4 = mk_payload(32'h4000);
    sdp_valid = 1'b1;
    sdp_payload = q1; tick();
    sdp_payload = q2; tick();
    sdp_payload = q3; tick();
    sdp_valid = 1'b0;
    chk("ovf_set", {63'd0, ovf}, 64'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", {63'd0, ovf}, 64'd0);
    ovf_clr = 1'b1; sdp_valid = 1'b1; sdp_payload = q3; tick();
    ovf_clr = 1'b0; sdp_valid = 1'b0;
    chk("ovf_set_wins", {63'd0, ovf}, 64'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr2", {63'd0, ovf}, 64'd0);

    // Write/pop collision while full, then back-to-back gap timing
    blank = 1'b1;
    recv("col_q1", q1, 1'b1, q4, idle);
    chk("col_ovf", {63'd0, ovf}, 64'd0);
    recv("col_q2", q2, 1'b0, '0, idle);
    chk("b2b_gap1", 64'(idle), 64'd3);
    recv("col_q4", q4, 1'b0, '0, idle);
    chk("b2b_gap2", 64'(idle), 64'd3);
    chk("b2b_pkt", {48'd0, pkt_cnt}, 64'd5);
    repeat (6) tick();
    chk("q3_lost_valid", {63'd0, tx_valid}, 64'd0);
    chk("q3_lost_busy", {63'd0, busy}, 64'd0);

    // cke toggling: transfers only on cke=1, outputs frozen otherwise
    q5 = mk_payload(32'h5000);
    sdp_valid = 1'b1; sdp_payload = q5; tick(); sdp_valid = 1'b0;
    words = 0;
    for (int cyc = 0; cyc < 80 && words < 10; cyc++) begin
      cke = (cyc % 2 == 0);
      pv = tx_valid; pd = tx_data; ps = tx_sop; pe = tx_eop;
      if (tx_valid && cke) begin
        chk($sformatf("cke_w%0d", words), {32'd0, tx_data}, {32'd0, q5[words*32 +: 32]});
        words++;
      end
      tick();
      if (!cke) begin
        chk("cke_hold_valid", {63'd0, tx_valid}, {63'd0, pv});
        chk("cke_hold_data", {32'd0, tx_data}, {32'd0, pd});
        chk("cke_hold_sop", {63'd0, tx_sop}, {63'd0, ps});
        chk("cke_hold_eop", {63'd0, tx_eop}, {63'd0, pe});
      end
    end
    cke = 1'b1;
    tick();
    chk("cke_pkt", {48'd0, pkt_cnt}, 64'd6);
    repeat (5) tick();

    // Reset in the middle of a packet
    q6 = mk_payload(32'h6000);
    sdp_valid = 1'b1; sdp_payload = q6; tick(); sdp_valid = 1'b0;
    waited = 0;
    while (!(tx_valid && tx_data == q6[5*32 +: 32]) && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL rst_mid_timeout: word 5 never presented");
    end
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", {63'd0, tx_valid}, 64'd0);
    chk("rstmid_data", {32'd0, tx_data}, 64'd0);
    chk("rstmid_sop", {63'd0, tx_sop}, 64'd0);
    chk("rstmid_eop", {63'd0, tx_eop}, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_pkt", {48'd0, pkt_cnt}, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_valid", {63'd0, tx_valid}, 64'd0);
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
    end

    // Randomized traffic against the queue model, then drain
    for (int i = 0; i < 3000; i++) rand_step(1'b0);
    for (int i = 0; i < 400 && (m_q.size() != 0); i++) rand_step(1'b1);
    repeat (6) rand_step(1'b1);
    chk("drain_busy", {63'd0, busy}, 64'd0);
    chk("drain_pkt", {48'd0, pkt_cnt}, {48'd0, 16'(m_pkt)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
